// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating MEM back-pressure counter.
module ex_mem_skid_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SKID_EN    = 1,
  parameter int DEBUG_EN   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  // EX side
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [XLEN-1:0]       i_debug_pc,
  input  logic [XLEN-1:0]       i_debug_inst,
  input  logic [XLEN-1:0]       i_rs_2,
  input  logic [REG_ADDR_W-1:0] i_rd_num,
  input  logic [XLEN-1:0]       i_alu_out,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_func_3,
  input  logic                  i_op_type,
  // MEM side
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       debug_pc,
  output logic [XLEN-1:0]       debug_inst,
  output logic [XLEN-1:0]       rs_2,
  output logic [REG_ADDR_W-1:0] rd_num,
  output logic [XLEN-1:0]       alu_out,
  output logic [6:0]            opcode,
  output logic [2:0]            func_3,
  output logic                  op_type,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [1:0]            o_state
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high; the producer holds valid and payload steady until that edge, and the
  // consumer may not make ready depend on the producer's valid.

  localparam int CW = 2 * XLEN + REG_ADDR_W + 11;
  localparam int DW = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_ld_main_in;
  logic           w_ld_main_skid;
  logic           w_ld_skid;
  logic [CW-1:0]  w_in_core;
  logic [CW-1:0]  w_skid_core;
  logic [CW-1:0]  r_main_core;
  logic [CNT_W-1:0] r_stall_cnt;

  assign o_valid    = (r_state != ST_EMPTY);
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;
  assign o_state    = r_state;
  assign w_in_core  = {i_rs_2, i_alu_out, i_rd_num, i_opcode, i_func_3, i_op_type};

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_in_fire && i_ready) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire && (SKID_EN != 0)) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = ST_SKID;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush drops everything held plus whatever EX fires this cycle.
    if (i_flush) begin
      w_state_nxt    = ST_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush)     r_main_core <= '0;
    else if (w_ld_main_in)    r_main_core <= w_in_core;
    else if (w_ld_main_skid)  r_main_core <= w_skid_core;
  end

  assign {rs_2, alu_out, rd_num, opcode, func_3, op_type} = r_main_core;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic          r_ready;
      logic [CW-1:0] r_skid_core;

      always_ff @(posedge i_clk) begin
        if (i_rst) r_ready <= 1'b1;
        else       r_ready <= (w_state_nxt != ST_SKID);
      end

      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) r_skid_core <= '0;
        else if (w_ld_skid)   r_skid_core <= w_in_core;
      end

      assign o_ready     = r_ready & ~i_rst;
      assign w_skid_core = r_skid_core;
    end else begin : g_noskid
      logic w_unused_skid;
      assign w_unused_skid = w_ld_skid;
      assign o_ready       = ~i_rst & (~o_valid | i_ready);
      assign w_skid_core   = '0;
    end

    if (DEBUG_EN != 0) begin : g_dbg
      logic [DW-1:0] r_main_dbg;
      logic [DW-1:0] w_skid_dbg;

      if (SKID_EN != 0) begin : g_dbg_skid
        logic [DW-1:0] r_skid_dbg;
        always_ff @(posedge i_clk) begin
          if (i_rst || i_flush) r_skid_dbg <= '0;
          else if (w_ld_skid)   r_skid_dbg <= {i_debug_pc, i_debug_inst};
        end
        assign w_skid_dbg = r_skid_dbg;
      end else begin : g_dbg_noskid
        assign w_skid_dbg = '0;
      end

      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush)    r_main_dbg <= '0;
        else if (w_ld_main_in)   r_main_dbg <= {i_debug_pc, i_debug_inst};
        else if (w_ld_main_skid) r_main_dbg <= w_skid_dbg;
      end

      assign {debug_pc, debug_inst} = r_main_dbg;
    end else begin : g_nodbg
      logic w_unused_dbg;
      assign w_unused_dbg = ^{i_debug_pc, i_debug_inst};
      assign debug_pc     = '0;
      assign debug_inst   = '0;
    end
  endgenerate

  // Counts every cycle MEM back-pressures a valid entry, flush cycles included.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_cnt <= '0;
    else if (o_valid && !i_ready && (r_stall_cnt != CNT_MAX))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised EX/MEM pipeline register with a valid/ready handshake and an optional 2-entry skid buffer.
- Supports synchronous flush and a saturating back-pressure counter.
- Sits between the execute stage and the memory stage. It replaces the fixed-width, always-advancing EX/MEM latch so that MEM can stall on slow data memory without losing in-flight instructions.

Parameters:
- XLEN, 32, datapath width of pc, inst, rs_2 and alu_out.
- REG_ADDR_W, 5, width of the destination register number.
- SKID_EN, 1. 1: two-entry skid buffer with registered o_ready. 0: single entry with combinational ready.
- DEBUG_EN, 1. 1: carry pc/inst debug fields. 0: debug outputs tied to 0 and no flops inferred.
- CNT_W, 16, width of the stall counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_flush  in  1  drop all held entries (branch mispredict or trap).
- i_valid  in  1  EX presents a valid instruction.
- o_ready  out  1  block can accept this cycle.
- i_debug_pc / i_debug_inst  in  XLEN  debug payload.
- i_rs_2  in  XLEN  store data.
- i_rd_num  in  REG_ADDR_W  destination register.
- i_alu_out  in  XLEN  ALU result / address.
- i_opcode  in  7  opcode.
- i_func_3  in  3  funct3.
- i_op_type  in  1  op type flag.
- o_valid  out  1  MEM-side entry valid.
- i_ready  in  1  MEM accepts this cycle.
- debug_pc, debug_inst, rs_2, rd_num, alu_out, opcode, func_3, op_type  out  matching widths  head-entry payload.
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0.

Behaviour:
- Fire definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- Reset (i_rst=1 at clock edge):
  - State goes to EMPTY.
  - o_valid=0; all payload outputs 0; skid entry 0; o_stall_cnt=0.
  - o_ready is forced 0 combinationally while i_rst=1, and is 1 on the first cycle after release.
  - Reset overrides flush and all traffic, including mid-transfer.
- Latency: 1 cycle from in_fire to o_valid=1 with that payload. The payload is stable while o_valid=1 and i_ready=0.
- SKID_EN=1 state machine (o_ready is registered, = state != SKID):
  - EMPTY: in_fire -> load main, FULL.
  - FULL:
    - out_fire & in_fire -> load main, stay FULL.
    - out_fire only -> EMPTY.
    - in_fire & !i_ready -> load skid, SKID.
  - SKID: o_ready=0. out_fire -> skid moves to main, FULL. Otherwise hold.
- Ordering: the skid entry is always younger than main, and the output order equals the input order.
- SKID_EN=0:
  - Single entry; o_ready = !o_valid | i_ready (combinational).
  - A load occurs on in_fire. o_valid clears on out_fire without in_fire.
- Flush (i_flush=1, i_rst=0):
  - Next state is EMPTY, o_valid=0, and all payload and skid fields are cleared to 0, so rd_num=0 acts as a bubble.
  - An instruction firing in the same cycle is discarded.
  - out_fire in the flush cycle still counts as delivered to MEM.
- o_stall_cnt:
  - +1 each cycle with o_valid & !i_ready, including the cycle in which i_flush=1 if the condition held.
  - Saturates at 2^CNT_W-1 and is not wrapped.
  - Cleared only by reset.
- No combinational path from i_valid or any payload input to any output, in either mode. With SKID_EN=1 there is also no path from i_ready to o_ready.

Test Plan:
- Reset with i_valid=1 and payload alu_out=0xDEADBEEF -> o_ready=0 and all outputs 0 during reset. The cycle after release: o_ready=1, o_valid=0.
- Streaming, i_ready=1, 4 instructions with pc=0x100,0x104,0x108,0x10C -> each appears on debug_pc exactly 1 cycle later, in order, with no gaps. o_stall_cnt stays 0.
- SKID_EN=1: hold i_ready=0 after pc=0x200, send pc=0x204 -> o_ready=0 the next cycle; debug_pc holds 0x200. Release i_ready -> 0x200, then 0x204, with none lost or duplicated. o_stall_cnt counts the exact stalled cycles.
- Flush while in SKID, with i_valid=1 and pc=0x300 in the same cycle -> next cycle o_valid=0, rd_num=0, o_ready=1. 0x300 never appears.
- SKID_EN=0, i_ready toggling 1,0,1 with continuous i_valid -> o_ready tracks !o_valid|i_ready in the same cycle; payload order is preserved.
- CNT_W=4, hold i_ready=0 for 20 cycles with o_valid=1 -> o_stall_cnt saturates at 15. Reset then returns it to 0.
